// File: rtl/shifter_pkg.sv
// Shared constants for the iterative shifter: FSM encoding, default width and
// the shift-amount width helper.
package shifter_pkg;

    localparam int unsigned DEF_WIDTH = 8;

    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_SHIFT = 2'b01;
    localparam logic [1:0] ST_DONE  = 2'b10;

    // Never narrower than one bit, so a degenerate WIDTH still elaborates.
    function automatic int unsigned shamt_width(input int unsigned width);
        return (width > 32'd1) ? unsigned'($clog2(width)) : 32'd1;
    endfunction

endpackage

// File: rtl/lshift_step.sv
// Combinational single-bit left step: zero-fill shift or rotate, with the bit
// leaving position WIDTH-1 reported on cout.
module lshift_step
    import shifter_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH-1:0] in,
    input  logic             rot,
    output logic [WIDTH-1:0] out,
    output logic             cout
);

    always_comb begin
        out  = {in[WIDTH-2:0], rot & in[WIDTH-1]};
        cout = in[WIDTH-1];
    end

endmodule

// File: rtl/iterative_left_shifter.sv
// Multi-cycle left shifter, one bit per cycle, with START/BUSY/DONE handshake.
// Build option SHIFTER_ROTATE_EN adds a rotate input captured with START.
module iterative_left_shifter
    import shifter_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned CNT_W = shamt_width(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] data1,
    input  logic [CNT_W-1:0] shamt,
`ifdef SHIFTER_ROTATE_EN
    input  logic             rotate,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             zero
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] step_out;
    logic             step_cout;
    logic             step_rot;

`ifdef SHIFTER_ROTATE_EN
    logic rot_q, rot_d;
    assign step_rot = rot_q;
`else
    assign step_rot = 1'b0;
`endif

    lshift_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .in   (result_q),
        .rot  (step_rot),
        .out  (step_out),
        .cout (step_cout)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        carry_d  = carry_q;
`ifdef SHIFTER_ROTATE_EN
        rot_d    = rot_q;
`endif
        case (state_q)
            ST_SHIFT: begin
                // The cnt==0 edge only moves to DONE, giving SHAMT+1 busy cycles.
                if (cnt_q != '0) begin
                    result_d = step_out;
                    carry_d  = step_cout;
                    cnt_d    = cnt_q - CNT_ONE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                // IDLE and DONE both accept, allowing back-to-back operations.
                if (start) begin
                    result_d = data1;
                    cnt_d    = shamt;
                    carry_d  = 1'b0;
                    state_d  = ST_SHIFT;
`ifdef SHIFTER_ROTATE_EN
                    rot_d    = rotate;
`endif
                end else begin
                    state_d = ST_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            result_q <= '0;
            carry_q  <= 1'b0;
`ifdef SHIFTER_ROTATE_EN
            rot_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            carry_q  <= carry_d;
`ifdef SHIFTER_ROTATE_EN
            rot_q    <= rot_d;
`endif
        end
    end

    always_comb begin
        busy   = (state_q == ST_SHIFT);
        done   = (state_q == ST_DONE);
        result = result_q;
        carry  = carry_q;
        zero   = (result_q == '0);
    end

endmodule

// File: tb/tb_iterative_left_shifter.sv
// Self-checking bench for iterative_left_shifter: cycle-count reference model
// plus directed vectors with literal expectations (rotate cases under SHIFTER_ROTATE_EN).
module tb_iterative_left_shifter;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       rotate = 1'b0;
    logic [7:0] data1 = 8'h00;
    logic [2:0] shamt = 3'd0;
    logic       busy, done, carry, zero;
    logic [7:0] result;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always #5 clk = ~clk;

    iterative_left_shifter dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .data1  (data1),
        .shamt  (shamt),
`ifdef SHIFTER_ROTATE_EN
        .rotate (rotate),
`endif
        .busy   (busy),
        .done   (done),
        .result (result),
        .carry  (carry),
        .zero   (zero)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Final value of a whole operation, computed in one go with wide arithmetic.
    function automatic void expect_op(input logic [7:0] d, input logic [2:0] s, input logic r,
                                      output logic [7:0] res, output logic c);
        logic [15:0] x;
        x   = {8'h00, d} << s;
        res = r ? (x[7:0] | x[15:8]) : x[7:0];
        c   = (s != 3'd0) ? x[8] : 1'b0;
    endfunction

    // Reference model: busy for shamt+1 cycles after accept, then a one-cycle done.
    int         m_left  = 0;
    bit         m_done  = 0;
    bit         m_valid = 0;
    bit         m_init  = 0;
    logic [7:0] m_result = 8'h00;
    logic [7:0] m_pend   = 8'h00;
    logic       m_carry  = 1'b0;
    logic       m_pend_c = 1'b0;

    initial forever begin
        @(posedge clk);
        cyc = cyc + 1;
        if (reset) begin
            m_init = 1; m_left = 0; m_done = 0;
            m_result = 8'h00; m_carry = 1'b0; m_valid = 1;
        end else if (m_left == 0) begin
            m_done = 0;
            if (start) begin
                expect_op(data1, shamt, rotate, m_pend, m_pend_c);
                m_left  = int'(shamt) + 1;
                m_valid = 0;
            end
        end else begin
            m_left--;
            if (m_left == 0) begin
                m_done = 1; m_result = m_pend; m_carry = m_pend_c; m_valid = 1;
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (m_init) begin
            check("model_busy", busy, m_left > 0);
            check("model_done", done, m_done);
            if (m_valid) begin
                check("model_result", result, m_result);
                check("model_carry", carry, m_carry);
                check("model_zero", zero, m_result == 8'h00);
            end
        end
    end

    task automatic start_op(input logic [7:0] d, input logic [2:0] s, input logic r,
                            output int acc);
        @(posedge clk);
        #1;
        start = 1'b1; data1 = d; shamt = s; rotate = r;
        @(posedge clk);
        #1;
        acc = cyc;
        // Scramble operands to show they are not re-sampled during the shift.
        start = 1'b0; data1 = 8'h5A; shamt = 3'd6; rotate = ~r;
    endtask

    task automatic wait_done(output int at, output bit ok);
        ok = 0;
        at = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                ok = 1;
                at = cyc;
                break;
            end
        end
        if (!ok) begin
            n_checks++;
            n_fail++;
            $display("FAIL done_timeout: no done within 20 cycles (t=%0t)", $time);
        end
    endtask

    task automatic run_op(input string name, input logic [7:0] d, input logic [2:0] s,
                          input logic r, input logic [7:0] exp_res, input logic exp_c);
        int acc, at;
        bit ok;
        start_op(d, s, r, acc);
        wait_done(at, ok);
        if (ok) begin
            check({name, "_latency"}, at - acc, int'(s) + 1);
            check({name, "_result"}, result, exp_res);
            check({name, "_carry"}, carry, exp_c);
            check({name, "_zero"}, zero, exp_res == 8'h00);
        end
    endtask

    initial begin
        int  acc, at, pulses;
        bit  ok;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_busy", busy, 1'b0);
        check("reset_done", done, 1'b0);
        check("reset_result", result, 8'h00);
        check("reset_carry", carry, 1'b0);
        check("reset_zero", zero, 1'b1);
        @(posedge clk);
        #1 reset = 1'b0;

        run_op("b5_by3", 8'hB5, 3'd3, 1'b0, 8'hA8, 1'b1);
        run_op("3c_by0", 8'h3C, 3'd0, 1'b0, 8'h3C, 1'b0);
        run_op("c3_by7", 8'hC3, 3'd7, 1'b0, 8'h80, 1'b1);

        // Second request while busy must be ignored.
        start_op(8'h80, 3'd7, 1'b0, acc);
        @(posedge clk);
        #1 start = 1'b1; data1 = 8'hFF; shamt = 3'd1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(at, ok);
        if (ok) begin
            check("80_by7_latency", at - acc, 8);
            check("80_by7_result", result, 8'h00);
            check("80_by7_carry", carry, 1'b0);
            check("80_by7_zero", zero, 1'b1);
        end

        // Reset after two shift steps aborts with no done pulse.
        start_op(8'h0F, 3'd5, 1'b0, acc);
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("abort_busy", busy, 1'b0);
        check("abort_result", result, 8'h00);
        check("abort_zero", zero, 1'b1);
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (done === 1'b1) pulses++;
        end
        check("abort_no_done", pulses, 0);

        // Back-to-back: new START presented in the DONE cycle.
        run_op("12_by1", 8'h12, 3'd1, 1'b0, 8'h24, 1'b0);
        start = 1'b1; data1 = 8'h01; shamt = 3'd2; rotate = 1'b0;
        @(posedge clk);
        #1 acc = cyc;
        start = 1'b0;
        wait_done(at, ok);
        if (ok) begin
            check("b2b_latency", at - acc, 3);
            check("b2b_result", result, 8'h04);
            check("b2b_carry", carry, 1'b0);
        end

`ifdef SHIFTER_ROTATE_EN
        run_op("rot81_by1", 8'h81, 3'd1, 1'b1, 8'h03, 1'b1);
        run_op("rotf0_by4", 8'hF0, 3'd4, 1'b1, 8'h0F, 1'b1);
`endif

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
